// File: rtl/multibeam_mac_engine_pkg.sv
// Shared types and default sizing for the multi-beam MAC engine.
package multibeam_mac_engine_pkg;

    localparam int unsigned NUM_BEAMS_DEF      = 4;
    localparam int unsigned OUT_WIDTH_DEF      = 32;
    localparam int unsigned MACS_PER_CYCLE_DEF = 4;
    localparam int unsigned OUT_FIFO_DEPTH_DEF = 8;
    localparam int unsigned SAT_CNT_W          = 16;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StWrite
    } state_e;

endpackage

// File: rtl/multibeam_mac_engine_bf_out_fifo.sv
// Show-ahead synchronous FIFO for finished beams; a push into a full FIFO is
// accepted when a pop frees the head slot in the same cycle.
module bf_out_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_mem  <= '{default: '0};
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr                <= r_wptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/multibeam_mac_engine.sv
// Time-multiplexed beamformer: per sample, N beams each accumulated over G groups of
// parallel conjugate complex MACs, then shifted, saturated and queued.
module multibeam_mac_engine
    import multibeam_mac_engine_pkg::*;
#(
    parameter int unsigned NUM_CH         = 24,
    parameter int unsigned NUM_BEAMS      = NUM_BEAMS_DEF,
    parameter int unsigned IQ_WIDTH       = 16,
    parameter int unsigned COEFF_WIDTH    = 16,
    parameter int unsigned ACC_WIDTH      = 48,
    parameter int unsigned OUT_WIDTH      = OUT_WIDTH_DEF,
    parameter int unsigned MACS_PER_CYCLE = MACS_PER_CYCLE_DEF,
    parameter int unsigned OUT_FIFO_DEPTH = OUT_FIFO_DEPTH_DEF,
    localparam int unsigned NB_W          = $clog2(NUM_BEAMS + 1),
    localparam int unsigned IDX_W         = (NUM_BEAMS > 1) ? $clog2(NUM_BEAMS) : 1
) (
    input  logic                                      core_clk,
    input  logic                                      core_rst_n,
    input  logic [NUM_CH*2*IQ_WIDTH-1:0]              sample_data_i,
    input  logic                                      sample_valid_i,
    output logic                                      sample_ready_o,
    input  logic [NUM_BEAMS*NUM_CH*2*COEFF_WIDTH-1:0] coeff_data_i,
    input  logic [NB_W-1:0]                           cfg_num_beams,
    input  logic [5:0]                                cfg_shift,
    output logic [OUT_WIDTH-1:0]                      beam_real_o,
    output logic [OUT_WIDTH-1:0]                      beam_imag_o,
    output logic [IDX_W-1:0]                          beam_idx_o,
    output logic                                      beam_last_o,
    output logic                                      beam_valid_o,
    input  logic                                      beam_ready_i,
    output logic                                      busy_o,
    output logic [SAT_CNT_W-1:0]                      sat_count_o
);
    localparam int unsigned G       = NUM_CH / MACS_PER_CYCLE;
    localparam int unsigned GRP_W   = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PROD_W  = IQ_WIDTH + COEFF_WIDTH;
    localparam int unsigned ENTRY_W = 2 * OUT_WIDTH + IDX_W + 1;
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    state_e                       r_state;
    logic [NUM_CH*2*IQ_WIDTH-1:0] r_sample;
    logic [NB_W-1:0]              r_nbeams;
    logic [5:0]                   r_shift;
    logic [IDX_W-1:0]             r_beam;
    logic [GRP_W-1:0]             r_grp;
    logic signed [ACC_WIDTH-1:0]  r_acc_re;
    logic signed [ACC_WIDTH-1:0]  r_acc_im;
    logic [SAT_CNT_W-1:0]         r_sat_cnt;

    logic signed [IQ_WIDTH-1:0]    w_xr [NUM_CH];
    logic signed [IQ_WIDTH-1:0]    w_xi [NUM_CH];
    logic signed [COEFF_WIDTH-1:0] w_wr [NUM_BEAMS][NUM_CH];
    logic signed [COEFF_WIDTH-1:0] w_wi [NUM_BEAMS][NUM_CH];
    logic signed [ACC_WIDTH-1:0]   w_part_re [MACS_PER_CYCLE+1];
    logic signed [ACC_WIDTH-1:0]   w_part_im [MACS_PER_CYCLE+1];
    logic signed [ACC_WIDTH-1:0]   w_sh_re;
    logic signed [ACC_WIDTH-1:0]   w_sh_im;
    logic [OUT_WIDTH-1:0]          w_out_re;
    logic [OUT_WIDTH-1:0]          w_out_im;
    logic                          w_clip_re;
    logic                          w_clip_im;
    logic [1:0]                    w_clip_cnt;
    logic [SAT_CNT_W:0]            w_sat_sum;
    logic [NB_W-1:0]               w_nbeams;
    logic                          w_last;
    logic                          w_pop;
    logic                          w_push;
    logic                          w_fifo_full;
    logic                          w_fifo_empty;
    logic [ENTRY_W-1:0]            w_push_data;
    logic [ENTRY_W-1:0]            w_head_data;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign w_xr[c] = r_sample[(2*c)*IQ_WIDTH +: IQ_WIDTH];
        assign w_xi[c] = r_sample[(2*c+1)*IQ_WIDTH +: IQ_WIDTH];
        for (genvar b = 0; b < NUM_BEAMS; b++) begin : g_beam
            assign w_wr[b][c] = coeff_data_i[(b*NUM_CH+c)*2*COEFF_WIDTH +: COEFF_WIDTH];
            assign w_wi[b][c] = coeff_data_i[(b*NUM_CH+c)*2*COEFF_WIDTH+COEFF_WIDTH +: COEFF_WIDTH];
        end
    end

    assign w_part_re[0] = '0;
    assign w_part_im[0] = '0;

    // Conjugate MAC lanes: each lane covers one channel of the current group.
    for (genvar l = 0; l < MACS_PER_CYCLE; l++) begin : g_lane
        logic [CH_W-1:0]          w_ch;
        logic signed [PROD_W-1:0] w_xr_e, w_xi_e, w_wr_e, w_wi_e;
        assign w_ch   = CH_W'(32'(r_grp) * MACS_PER_CYCLE + l);
        assign w_xr_e = PROD_W'(w_xr[w_ch]);
        assign w_xi_e = PROD_W'(w_xi[w_ch]);
        assign w_wr_e = PROD_W'(w_wr[r_beam][w_ch]);
        assign w_wi_e = PROD_W'(w_wi[r_beam][w_ch]);
        assign w_part_re[l+1] = w_part_re[l] + ACC_WIDTH'(w_xr_e * w_wr_e)
                                             + ACC_WIDTH'(w_xi_e * w_wi_e);
        assign w_part_im[l+1] = w_part_im[l] + ACC_WIDTH'(w_xi_e * w_wr_e)
                                             - ACC_WIDTH'(w_xr_e * w_wi_e);
    end

    assign w_sh_re = r_acc_re >>> r_shift;
    assign w_sh_im = r_acc_im >>> r_shift;

    always_comb begin
        w_clip_re = 1'b0;
        w_out_re  = w_sh_re[OUT_WIDTH-1:0];
        if (w_sh_re > OUT_MAX) begin
            w_clip_re = 1'b1;
            w_out_re  = OUT_MAX[OUT_WIDTH-1:0];
        end else if (w_sh_re < OUT_MIN) begin
            w_clip_re = 1'b1;
            w_out_re  = OUT_MIN[OUT_WIDTH-1:0];
        end
        w_clip_im = 1'b0;
        w_out_im  = w_sh_im[OUT_WIDTH-1:0];
        if (w_sh_im > OUT_MAX) begin
            w_clip_im = 1'b1;
            w_out_im  = OUT_MAX[OUT_WIDTH-1:0];
        end else if (w_sh_im < OUT_MIN) begin
            w_clip_im = 1'b1;
            w_out_im  = OUT_MIN[OUT_WIDTH-1:0];
        end
    end

    assign w_clip_cnt  = {1'b0, w_clip_re} + {1'b0, w_clip_im};
    assign w_sat_sum   = {1'b0, r_sat_cnt} + (SAT_CNT_W+1)'(w_clip_cnt);
    assign w_nbeams    = (cfg_num_beams == '0 || cfg_num_beams > NB_W'(NUM_BEAMS))
                       ? NB_W'(NUM_BEAMS) : cfg_num_beams;
    assign w_last      = (r_beam == IDX_W'(r_nbeams - NB_W'(1)));
    assign w_pop       = beam_valid_o && beam_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO need not stall.
    assign w_push      = (r_state == StWrite) && (!w_fifo_full || w_pop);
    assign w_push_data = {w_out_re, w_out_im, r_beam, w_last};

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            r_state   <= StIdle;
            r_sample  <= '0;
            r_nbeams  <= '0;
            r_shift   <= '0;
            r_beam    <= '0;
            r_grp     <= '0;
            r_acc_re  <= '0;
            r_acc_im  <= '0;
            r_sat_cnt <= '0;
        end else begin
            if (w_push) begin
                r_sat_cnt <= w_sat_sum[SAT_CNT_W] ? '1 : w_sat_sum[SAT_CNT_W-1:0];
            end
            case (r_state)
                StIdle: begin
                    if (sample_valid_i) begin
                        r_sample <= sample_data_i;
                        r_nbeams <= w_nbeams;
                        r_shift  <= cfg_shift;
                        r_beam   <= '0;
                        r_grp    <= '0;
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                        r_state  <= StMac;
                    end
                end
                StMac: begin
                    r_acc_re <= r_acc_re + w_part_re[MACS_PER_CYCLE];
                    r_acc_im <= r_acc_im + w_part_im[MACS_PER_CYCLE];
                    if (r_grp == GRP_W'(G - 1)) begin
                        r_state <= StWrite;
                    end else begin
                        r_grp <= r_grp + GRP_W'(1);
                    end
                end
                StWrite: begin
                    if (w_push) begin
                        if (w_last) begin
                            r_state <= StIdle;
                        end else begin
                            r_beam   <= r_beam + IDX_W'(1);
                            r_grp    <= '0;
                            r_acc_re <= '0;
                            r_acc_im <= '0;
                            r_state  <= StMac;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    bf_out_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_out_fifo (
        .i_clk   (core_clk),
        .i_rst_n (core_rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign {beam_real_o, beam_imag_o, beam_idx_o, beam_last_o} = w_head_data;
    assign beam_valid_o   = !w_fifo_empty;
    assign sample_ready_o = (r_state == StIdle);
    assign busy_o         = (r_state != StIdle);
    assign sat_count_o    = r_sat_cnt;

endmodule

// File: doc/multibeam_mac_engine.md
Name: multibeam_mac_engine

Overview:
Time-multiplexed multi-beam beamforming engine. It takes one complex channel vector per sample and produces up to NUM_BEAMS beam outputs. Each beam is a conjugate-weighted sum over NUM_CH channels, computed with MACS_PER_CYCLE parallel complex MACs. The engine sits between the ADC lane aggregation and the coefficient double buffer, and streams scaled, saturated beams through an output FIFO with valid/ready. It generalises the single-beam core: multiple beams, runtime beam count, programmable output shift, saturation with counting, and backpressure toward the sample source.

Parameters:
NUM_CH, 24, complex channels per sample vector
NUM_BEAMS, 4, maximum beams per sample
IQ_WIDTH, 16, signed I/Q sample width
COEFF_WIDTH, 16, signed coefficient real/imag width
ACC_WIDTH, 48, signed accumulator width (must be >= IQ_WIDTH+COEFF_WIDTH+1+clog2(NUM_CH))
OUT_WIDTH, 32, signed output real/imag width
MACS_PER_CYCLE, 4, parallel complex MACs per cycle; must divide NUM_CH; G = NUM_CH/MACS_PER_CYCLE
OUT_FIFO_DEPTH, 8, output FIFO entries (power of 2)

Ports:
core_clk  in  1  core clock
core_rst_n  in  1  asynchronous active-low reset
sample_data_i  in  NUM_CH*2*IQ_WIDTH  channel c: real at [(2c)*IQ_WIDTH +: IQ_WIDTH], imag at [(2c+1)*IQ_WIDTH +: IQ_WIDTH]
sample_valid_i  in  1  sample vector valid
sample_ready_o  out  1  engine accepts a sample this cycle
coeff_data_i  in  NUM_BEAMS*NUM_CH*2*COEFF_WIDTH  beam b, channel c at base (b*NUM_CH+c)*2*COEFF_WIDTH, real then imag; held stable by the source while busy_o=1
cfg_num_beams  in  clog2(NUM_BEAMS+1)  active beams; 0 or >NUM_BEAMS means NUM_BEAMS
cfg_shift  in  6  arithmetic right shift applied before saturation
beam_real_o  out  OUT_WIDTH  beam real part
beam_imag_o  out  OUT_WIDTH  beam imag part
beam_idx_o  out  clog2(NUM_BEAMS)  beam index
beam_last_o  out  1  last beam of this sample
beam_valid_o  out  1  FIFO head valid
beam_ready_i  in  1  downstream pop
busy_o  out  1  state != IDLE
sat_count_o  out  16  saturated components, sticky at 0xFFFF

Behaviour:
- Reset values: all outputs 0 except sample_ready_o=1. State is IDLE, FIFO is empty, accumulators are 0. A reset asserted mid-computation discards the in-flight sample and all FIFO contents.
- FSM states:
  - IDLE: sample_ready_o=1. When sample_valid_i=1, latch sample_data_i, cfg_num_beams (clamped) and cfg_shift. Set beam=0, grp=0, clear accumulators, go to MAC.
  - MAC: each cycle, for channels grp*MACS_PER_CYCLE .. +MACS_PER_CYCLE-1, acc_re += xr*wr + xi*wi and acc_im += xi*wr - xr*wi, using beam `beam` coefficients. Products are sign-extended to ACC_WIDTH. After grp = G-1, go to WRITE.
  - WRITE: if the FIFO is not full, push {sat(acc_re>>>shift), sat(acc_im>>>shift), beam, beam==N-1}. Then, if beam==N-1, go to IDLE; otherwise beam++, grp=0, clear accumulators, go to MAC. If the FIFO is full, stall in WRITE with accumulators held.
- sample_ready_o = (state==IDLE). Inputs are never dropped. Per-sample throughput is N*(G+1)+1 cycles.
- Shift is arithmetic (rounds toward -inf). Saturation clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. sat_count_o increments by 0, 1 or 2 per push, one per clipped component, and stops at 0xFFFF.
- Latency: a sample accepted at cycle 0 pushes beam 0 at cycle G+1. The FIFO is show-ahead, so beam_valid_o=1 at cycle G+2 when the FIFO was empty.
- FIFO: pop when beam_valid_o & beam_ready_i. A simultaneous push and pop is legal when full (the pop frees the slot in the same cycle) and when empty (data appears next cycle). Pointers wrap modulo OUT_FIFO_DEPTH.
- cfg_* changes while busy have no effect until the next accept.

Decomposition:
- beamformer_defines.vh adds `NUM_BEAMS, `OUT_WIDTH, `MACS_PER_CYCLE, `OUT_FIFO_DEPTH and a sat-count width constant.
- Sub-module bf_out_fifo: synchronous show-ahead FIFO, parametrised in width and depth, with full and empty flags.
- Complex MAC lanes stay inline as a generate loop.

Test Plan:
- NUM_CH=24, all x=(100,0), beam0 w=(2,0), beam1 w=(0,1), cfg_num_beams=2, shift=0 -> two beams: (4800,0) idx0 last0, then (0,-2400) idx1 last1; beam_valid_o rises 8 cycles after accept.
- x=(32767,0), w=(32767,0) all channels, shift=0 -> beam real = 0x7FFFFFFF, imag = 0, sat_count_o increments by 1. Same stimulus with shift=8 -> real = 24*32767*32767>>8 = 100,657,152, no saturation.
- beam_ready_i held 0, 3 samples x 4 beams -> FIFO fills at 8 entries, engine stalls in WRITE, sample_ready_o=0. Release ready -> all 12 beams emerge in order with no loss or duplication.
- cfg_num_beams=0 and cfg_num_beams=7 -> each produces NUM_BEAMS=4 beams per sample, with beam_last_o on idx 3.
- core_rst_n pulsed low during MAC of beam 2 -> all outputs return to reset values immediately. The first sample after release yields correct beam 0.
- Back-to-back samples with sample_valid_i held high and beam_ready_i=1 -> accepts spaced exactly N*(G+1)+1 cycles apart, and cfg changes between samples take effect from the next accept.
